// File: rtl/imm_extend_pipe.sv
// ID-stage immediate generator: extends I/S/B/J/U/Z immediates to XLEN, forms pc + imm,
// and holds the result in a single-entry valid/ready register with stall and flush.
module imm_extend_pipe #(
    parameter int XLEN       = 32,
    parameter bit HAS_TARGET = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    // The instr port carries bits [31:7]; B rebases architectural bit numbers onto it.
    localparam int B = 7;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_J = 3'b011,
        FMT_U = 3'b100,
        FMT_Z = 3'b101
    } imm_fmt_e;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_d;
    logic            illegal_d;
    logic            load;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        imm32     = '0;
        illegal_d = 1'b0;
        case (imm_fmt_e'(imm_src))
            FMT_I: imm32 = {{20{instr[31-B]}}, instr[31-B:20-B]};
            FMT_S: imm32 = {{20{instr[31-B]}}, instr[31-B:25-B], instr[11-B:7-B]};
            FMT_B: imm32 = {{19{instr[31-B]}}, instr[31-B], instr[7-B], instr[30-B:25-B],
                            instr[11-B:8-B], 1'b0};
            FMT_J: imm32 = {{11{instr[31-B]}}, instr[31-B], instr[19-B:12-B], instr[20-B],
                            instr[30-B:21-B], 1'b0};
            FMT_U: imm32 = {instr[31-B:12-B], 12'b0};
            FMT_Z: imm32 = {27'b0, instr[19-B:15-B]};
            default: illegal_d = 1'b1;
        endcase
    end

    // Z and illegal leave bit 31 clear, so one sign-extension serves every format.
    assign imm_d    = XLEN'(signed'(imm32));
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            imm_ext   <= '0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            imm_ext   <= imm_d;
            illegal   <= illegal_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    if (HAS_TARGET) begin : g_target
        logic [XLEN-1:0] target_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                target_q <= '0;
            end else if (load) begin
                target_q <= pc + imm_d;
            end
        end

        assign target = target_q;
    end else begin : g_no_target
        assign target = '0;
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: formats, backpressure, streaming, flush, illegal
// encodings and asynchronous reset, on a 32-bit instance and a 64-bit no-target instance.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_ext;
    logic [31:0] target;
    logic        illegal;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] imm_ext64;
    logic [63:0] target64;
    logic        illegal64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .HAS_TARGET(1'b1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .imm_src   (imm_src),
        .pc        (pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_ext   (imm_ext),
        .target    (target),
        .illegal   (illegal)
    );

    imm_extend_pipe #(.XLEN(64), .HAS_TARGET(1'b0)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .instr     (instr),
        .imm_src   (imm_src),
        .pc        ({32'h0, pc}),
        .flush     (flush),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .imm_ext   (imm_ext64),
        .target    (target64),
        .illegal   (illegal64)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] word, input logic [2:0] src, input logic [31:0] pc_v);
        in_valid = 1'b1;
        instr    = word[31:7];
        imm_src  = src;
        pc       = pc_v;
    endtask

    task automatic send_check(input string tag, input logic [31:0] word, input logic [2:0] src,
                              input logic [31:0] pc_v, input logic [31:0] e_imm,
                              input logic [31:0] e_tgt, input logic e_ill);
        drive(word, src, pc_v);
        step();
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".imm"}, 64'(imm_ext), 64'(e_imm));
        check({tag, ".target"}, 64'(target), 64'(e_tgt));
        check({tag, ".illegal"}, 64'(illegal), 64'(e_ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        imm_src   = '0;
        pc        = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.imm", 64'(imm_ext), 64'd0);
        check("rst.target", 64'(target), 64'd0);
        check("rst.illegal", 64'(illegal), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Formats.
        send_check("i_neg1", 32'hFFF0_0000, 3'b000, 32'h100, 32'hFFFF_FFFF, 32'h0000_00FF, 1'b0);
        check("i_neg1.in_ready", 64'(in_ready), 64'd1);
        send_check("s_fmt", 32'h8000_0280, 3'b001, 32'h10, 32'hFFFF_F805, 32'hFFFF_F815, 1'b0);
        send_check("b_fmt", 32'hFE00_0C80, 3'b010, 32'h40, 32'hFFFF_FFF8, 32'h0000_0038, 1'b0);
        send_check("j_fmt", 32'h1000_0000, 3'b011, 32'h1000, 32'h0000_0100, 32'h0000_1100, 1'b0);
        send_check("u_fmt", 32'h1234_5000, 3'b100, 32'h0, 32'h1234_5000, 32'h1234_5000, 1'b0);
        send_check("u_neg", 32'h8000_0000, 3'b100, 32'h4, 32'h8000_0000, 32'h8000_0004, 1'b0);
        check("u64.imm", imm_ext64, 64'hFFFF_FFFF_8000_0000);
        check("u64.target", target64, 64'h0);
        check("u64.valid", 64'(out_valid64), 64'd1);
        send_check("z_fmt", 32'h800F_8000, 3'b101, 32'h20, 32'h0000_001F, 32'h0000_003F, 1'b0);
        send_check("wrap", 32'h0100_0000, 3'b000, 32'hFFFF_FFF8, 32'h0000_0010, 32'h0000_0008, 1'b0);

        // Backpressure: load A, then stall three cycles with B waiting.
        send_check("bp_a", 32'h0050_0000, 3'b000, 32'h200, 32'h5, 32'h205, 1'b0);
        out_ready = 1'b0;
        drive(32'h00A0_0000, 3'b000, 32'h300);
        #1;
        check("bp.in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.hold_imm", 64'(imm_ext), 64'h5);
            check("bp.hold_target", 64'(target), 64'h205);
            check("bp.hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", 64'(in_ready), 64'd1);
        step();
        check("bp_b.valid", 64'(out_valid), 64'd1);
        check("bp_b.imm", 64'(imm_ext), 64'hA);
        check("bp_b.target", 64'(target), 64'h30A);

        // Back-to-back stream of four.
        for (int i = 0; i < 4; i++) begin
            send_check("stream", 32'((i + 1) << 20), 3'b000, 32'h400,
                       32'(i + 1), 32'(32'h400 + i + 1), 1'b0);
        end
        in_valid = 1'b0;
        step();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Flush kills the held entry and the incoming one.
        send_check("pre_flush", 32'h0070_0000, 3'b000, 32'h0, 32'h7, 32'h7, 1'b0);
        drive(32'h0090_0000, 3'b000, 32'h0);
        flush = 1'b1;
        step();
        check("flush.valid", 64'(out_valid), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush.dropped", 64'(out_valid), 64'd0);

        // Unsupported encodings still flow through with a zero immediate.
        send_check("ill_110", 32'hFFFF_FF80, 3'b110, 32'h500, 32'h0, 32'h500, 1'b1);
        send_check("ill_111", 32'hFFFF_FF80, 3'b111, 32'h600, 32'h0, 32'h600, 1'b1);
        check("ill64.illegal", 64'(illegal64), 64'd1);
        send_check("legal_after", 32'h0030_0000, 3'b000, 32'h0, 32'h3, 32'h3, 1'b0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        drive(32'h0040_0000, 3'b000, 32'h0);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 64'(out_valid), 64'd0);
        check("arst.imm", 64'(imm_ext), 64'd0);
        check("arst.target", 64'(target), 64'd0);
        check("arst.illegal", 64'(illegal), 64'd0);
        check("arst.imm64", imm_ext64, 64'd0);
        step();
        check("arst.held", 64'(out_valid), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_check("post_rst", 32'hFFE0_0000, 3'b000, 32'h80, 32'hFFFF_FFFE, 32'h7E, 1'b0);
        in_valid = 1'b0;
        step();
        check("post_rst.drain", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
